astro_arena: RTL

Multi-asteroid successor to the single-asteroid game top. Tracks up to `N_AST` asteroids on a `COORD_W`-bit square grid, all converging on a ship fixed at grid centre. Resolves directional shots, a once-per-game special attack, collisions and lives, and exposes score, occupancy and debug state. Sits directly below the board wrapper, which drives buttons, spawns and seven-segment decoders.

---
 rtl/astro_arena_if.sv | 37 +++
 rtl/astro_arena.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/astro_arena_if.sv
// Player, spawn and status bundle between the board wrapper and astro_arena.
// master: board wrapper side (drives player input, spawns, debug select).
// slave : astro_arena side (drives game status, score, occupancy, debug view).
interface astro_arena_if #(
    parameter int unsigned N_AST   = 4,
    parameter int unsigned COORD_W = 4
);
    logic               iniciar;
    logic [5:0]         jogada;
    logic               spawn_valid;
    logic [COORD_W-1:0] spawn_x;
    logic [COORD_W-1:0] spawn_y;
    logic               spawn_ready;
    logic [2:0]         db_sel;
    logic               tiro;
    logic               acertou;
    logic               colisao;
    logic               perdeu;
    logic [3:0]         vidas;
    logic [7:0]         pontos;
    logic [N_AST-1:0]   ativos;
    logic [3:0]         db_estado;
    logic [COORD_W-1:0] db_ast_x;
    logic [COORD_W-1:0] db_ast_y;

    modport master (
        output iniciar, jogada, spawn_valid, spawn_x, spawn_y, db_sel,
        input  spawn_ready, tiro, acertou, colisao, perdeu, vidas, pontos,
               ativos, db_estado, db_ast_x, db_ast_y
    );

    modport slave (
        input  iniciar, jogada, spawn_valid, spawn_x, spawn_y, db_sel,
        output spawn_ready, tiro, acertou, colisao, perdeu, vidas, pontos,
               ativos, db_estado, db_ast_x, db_ast_y
    );
endinterface

// File: rtl/astro_arena.sv
// Multi-asteroid game core: asteroids converge on a ship at grid centre;
// resolves directional shots, one special per game, collisions and lives.
// Ports: clock, reset (sync, active-low), bus (astro_arena_if.slave) carrying
// player input, spawn handshake, score/lives/occupancy and debug view.
module astro_arena #(
    parameter int unsigned N_AST     = 4,
    parameter int unsigned COORD_W   = 4,
    parameter int unsigned VIDAS_INI = 3,
    parameter int unsigned PERIODO   = 4
) (
    input  logic         clock,
    input  logic         reset,
    astro_arena_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(PERIODO);
    localparam int unsigned KW    = 4;
    localparam logic [COORD_W-1:0] C = COORD_W'(2 ** (COORD_W - 1));

    typedef enum logic [1:0] {IDLE = 2'd0, PREPARA = 2'd1, JOGANDO = 2'd2, FIM = 2'd3} estado_t;

    estado_t estado, estado_nx;
    logic em_prepara, em_jogo, em_fim;

    logic [1:0]         hist_q;     // previous jogada[5:4] for edge detection
    logic               spec_used;
    logic [CNT_W-1:0]   cnt;
    logic [N_AST-1:0]   ativos_q;
    logic [COORD_W-1:0] ast_x [N_AST];
    logic [COORD_W-1:0] ast_y [N_AST];
    logic [3:0]         vidas_q;
    logic [7:0]         pontos_q;
    logic               tiro_q, acertou_q, colisao_q;
    logic [COORD_W-1:0] db_x_q, db_y_q;

    logic               spawn_ready;
    logic [3:0]         dir;
    logic               dir_ok, fire_shot, fire_spec, tick, spawn_go, found, taken;
    logic [N_AST-1:0]   kill, col, ativos_d;
    logic [KW-1:0]      n_kill, n_col;
    logic [COORD_W-1:0] x_d [N_AST];
    logic [COORD_W-1:0] y_d [N_AST];
    logic [3:0]         vidas_d;
    logic [7:0]         pontos_d;
    logic [8:0]         pts_sum;
    logic [CNT_W-1:0]   cnt_d;
    logic [COORD_W-1:0] db_x_d, db_y_d;

    // One step toward the centre on a single axis
    function automatic logic [COORD_W-1:0] step(input logic [COORD_W-1:0] v);
        if (v < C)      return v + COORD_W'(1);
        else if (v > C) return v - COORD_W'(1);
        else            return v;
    endfunction

    // Asteroid lies on the half-axis selected by the one-hot direction
    function automatic logic mira(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y,
                                  input logic [3:0] d);
        return (d[0] && x == C && y < C) || (d[1] && x == C && y > C) ||
               (d[2] && y == C && x < C) || (d[3] && y == C && x > C);
    endfunction

    // State register
    always_ff @(posedge clock) begin
        if (!reset) estado <= IDLE;
        else        estado <= estado_nx;
    end

    // Next-state logic
    always_comb begin
        estado_nx = estado;
        case (estado)
            IDLE:    if (bus.iniciar) estado_nx = PREPARA;
            PREPARA: estado_nx = JOGANDO;
            JOGANDO: if (vidas_d == 4'd0) estado_nx = FIM;
            FIM:     if (bus.iniciar) estado_nx = PREPARA;
            default: estado_nx = IDLE;
        endcase
    end

    // State decode
    always_comb begin
        em_prepara = 1'b0;
        em_jogo    = 1'b0;
        em_fim     = 1'b0;
        case (estado)
            PREPARA: em_prepara = 1'b1;
            JOGANDO: em_jogo    = 1'b1;
            FIM:     em_fim     = 1'b1;
            default: ;
        endcase
    end

    assign spawn_ready = em_jogo && !(&ativos_q);

    // Per-cycle resolution: kills, movement, collisions, spawn, counters
    always_comb begin
        dir       = bus.jogada[3:0];
        dir_ok    = (dir != 4'd0) && ((dir & (dir - 4'd1)) == 4'd0);
        fire_shot = em_jogo && bus.jogada[5] && !hist_q[1] && dir_ok;
        fire_spec = em_jogo && bus.jogada[4] && !hist_q[0] && !spec_used;
        tick      = em_jogo && (cnt == CNT_W'(PERIODO - 1));
        spawn_go  = bus.spawn_valid && spawn_ready && !((bus.spawn_x == C) && (bus.spawn_y == C));
        kill      = '0;
        col       = '0;
        found     = 1'b0;
        taken     = 1'b0;
        n_kill    = '0;
        n_col     = '0;
        ativos_d  = ativos_q;
        db_x_d    = '0;
        db_y_d    = '0;

        for (int i = 0; i < int'(N_AST); i++) begin
            x_d[i] = ast_x[i];
            y_d[i] = ast_y[i];
            if (fire_shot && !found && ativos_q[i] && mira(ast_x[i], ast_y[i], dir)) begin
                kill[i] = 1'b1;
                found   = 1'b1;
            end
        end
        if (fire_spec) kill = kill | ativos_q;

        for (int i = 0; i < int'(N_AST); i++) begin
            n_kill = n_kill + KW'(kill[i]);
            if (tick && ativos_q[i] && !kill[i]) begin
                x_d[i] = step(ast_x[i]);
                y_d[i] = step(ast_y[i]);
            end
            if (em_jogo && ativos_q[i] && !kill[i] && x_d[i] == C && y_d[i] == C)
                col[i] = 1'b1;
            n_col = n_col + KW'(col[i]);
        end

        if (em_jogo) ativos_d = ativos_q & ~kill & ~col;

        // Spawn picks from slots free at cycle start, so same-cycle frees wait a cycle
        for (int i = 0; i < int'(N_AST); i++) begin
            if (spawn_go && !taken && !ativos_q[i]) begin
                ativos_d[i] = 1'b1;
                x_d[i]      = bus.spawn_x;
                y_d[i]      = bus.spawn_y;
                taken       = 1'b1;
            end
        end

        pts_sum  = 9'(pontos_q) + 9'(n_kill);
        vidas_d  = vidas_q;
        pontos_d = pontos_q;
        cnt_d    = cnt;
        if (em_jogo) begin
            vidas_d  = (vidas_q > n_col) ? vidas_q - n_col : 4'd0;
            pontos_d = (pts_sum > 9'd255) ? 8'd255 : pts_sum[7:0];
            cnt_d    = tick ? '0 : cnt + CNT_W'(1);
        end else if (em_prepara) begin
            ativos_d = '0;
            vidas_d  = 4'(VIDAS_INI);
            pontos_d = '0;
            cnt_d    = '0;
        end

        // Debug view tracks the slot contents being registered this edge
        for (int i = 0; i < int'(N_AST); i++) begin
            if (bus.db_sel == 3'(i) && ativos_d[i]) begin
                db_x_d = x_d[i];
                db_y_d = y_d[i];
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            hist_q    <= '0;
            spec_used <= 1'b0;
            cnt       <= '0;
            ativos_q  <= '0;
            vidas_q   <= '0;
            pontos_q  <= '0;
            tiro_q    <= 1'b0;
            acertou_q <= 1'b0;
            colisao_q <= 1'b0;
            db_x_q    <= '0;
            db_y_q    <= '0;
            for (int i = 0; i < int'(N_AST); i++) begin
                ast_x[i] <= '0;
                ast_y[i] <= '0;
            end
        end else begin
            hist_q    <= bus.jogada[5:4];
            spec_used <= em_prepara ? 1'b0 : (spec_used | fire_spec);
            cnt       <= cnt_d;
            ativos_q  <= ativos_d;
            vidas_q   <= vidas_d;
            pontos_q  <= pontos_d;
            tiro_q    <= fire_shot | fire_spec;
            acertou_q <= |kill;
            colisao_q <= |col;
            db_x_q    <= db_x_d;
            db_y_q    <= db_y_d;
            for (int i = 0; i < int'(N_AST); i++) begin
                ast_x[i] <= x_d[i];
                ast_y[i] <= y_d[i];
            end
        end
    end

    assign bus.spawn_ready = spawn_ready;
    assign bus.tiro        = tiro_q;
    assign bus.acertou     = acertou_q;
    assign bus.colisao     = colisao_q;
    assign bus.perdeu      = em_fim;
    assign bus.vidas       = vidas_q;
    assign bus.pontos      = pontos_q;
    assign bus.ativos      = ativos_q;
    assign bus.db_estado   = {2'b00, estado};
    assign bus.db_ast_x    = db_x_q;
    assign bus.db_ast_y    = db_y_q;
endmodule
